freq_meter: RTL and testbench

//  Measures the period and high time of a slow square wave, in clk cycles.

---
 rtl/freq_meter.sv | 153 +++++++++++++++
 tb/tb_freq_meter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Measures the period and the high time of a slow square wave (typically the
//   divided clock of the preceding divider stage), counted in clk cycles.
//   The input is treated as asynchronous data and is resynchronised first.
//   Each completed measurement updates period_out/high_out and raises valid
//   for one cycle; an abandoned measurement raises timeout for one cycle and
//   leaves the previous results untouched.
//
// Ports
//   clk         in   1      system clock, posedge
//   rst         in   1      synchronous active-high reset
//   sig_in      in   1      measured signal, asynchronous to clk
//   start       in   1      one-cycle request to begin one measurement
//   period_out  out  CNT_W  cycles between two consecutive synced rising edges
//   high_out    out  CNT_W  cycles from that rising edge to the next falling edge
//   valid       out  1      one-cycle pulse, results just updated
//   timeout     out  1      one-cycle pulse, measurement aborted
//   busy        out  1      high while a measurement is in progress
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    // The counter must be able to hold TIMEOUT without wrapping.
    generate
        if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
            $error("freq_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("freq_meter: SYNC_STAGES must be at least 2");
        end
    endgenerate

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_tmp;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_valid;
    logic                   r_timeout;

    logic w_s;
    logic w_rise;
    logic w_fall;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_prev;
    assign w_fall = ~w_s & r_s_prev;

    // Input synchronizer and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_prev <= w_s;
        end
    end

    // Measurement FSM. The high time is collected in r_high_tmp and only
    // committed together with the period, so an aborted measurement never
    // disturbs the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_high_tmp <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARM;
                        r_cnt   <= '0;
                    end
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_state    <= S_MEASURE;
                        r_cnt      <= CNT_ONE;
                        r_high_tmp <= '0;
                    end else if (r_cnt == CNT_TMO) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        r_state  <= S_DONE;
                        r_period <= r_cnt;
                        r_high   <= r_high_tmp;
                        r_valid  <= 1'b1;
                    end else if (r_cnt == CNT_TMO) begin
                        // A fall landing on the last allowed cycle cannot be
                        // followed by a rise in time, so abort here and keep
                        // the counter from stepping past TIMEOUT.
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        if (w_fall) begin
                            r_high_tmp <= r_cnt;
                        end
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//   Directed bench for freq_meter (CNT_W=16, TIMEOUT=20, SYNC_STAGES=2).
//   sig_in is produced by a clock-aligned square-wave generator, so periods
//   and high times are exact integer cycle counts.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    localparam int CNT_W = 16;
    localparam int TMO   = 20;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             start;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             timeout;
    logic             busy;

    int n_chk = 0;
    int n_bad = 0;

    int gen_p  = 8;
    int gen_h  = 4;
    bit gen_on = 1'b0;
    int ph     = 0;

    freq_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .start     (start),
        .period_out(period_out),
        .high_out  (high_out),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Square wave: high for gen_h cycles, low for gen_p-gen_h cycles.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_on) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                sig_in = (ph < gen_h);
                ph     = ph + 1;
                if (ph >= gen_p) ph = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled by exactly one posedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (at negedges) for sig_in to change to lvl.
    task automatic wait_sig(input string tag, input bit lvl);
        bit prev;
        prev = sig_in;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (prev != lvl && sig_in == lvl) return;
            prev = sig_in;
        end
        chk_val({tag, "_sig_to"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int lat);
        lat = -1;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            if (valid) begin
                lat = n;
                return;
            end
        end
        chk_val({tag, "_valid_to"}, 0, 1);
    endtask

    initial begin
        int lat;
        int nv;
        int nt;
        int first_t;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_period", int'(period_out), 0);
        chk_val("rst_high", int'(high_out), 0);
        chk_val("rst_valid", int'(valid), 0);
        chk_val("rst_timeout", int'(timeout), 0);
        chk_val("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // 1: period 8, high 4
        gen_p  = 8;
        gen_h  = 4;
        gen_on = 1'b1;
        wait_sig("t1", 1'b0);
        pulse_start();
        chk_val("t1_busy_arm", int'(busy), 1);
        wait_valid("t1", 40, lat);
        chk_val("t1_period", int'(period_out), 8);
        chk_val("t1_high", int'(high_out), 4);
        chk_val("t1_busy_valid", int'(busy), 1);
        chk_val("t1_no_timeout", int'(timeout), 0);
        @(negedge clk);
        chk_val("t1_busy_after", int'(busy), 0);
        chk_val("t1_valid_after", int'(valid), 0);

        // 2: period 16, high 12, second start while busy
        gen_p = 16;
        gen_h = 12;
        wait_sig("t2a", 1'b0);
        wait_sig("t2b", 1'b0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk_val("t2_busy_2nd", int'(busy), 1);
        pulse_start();
        wait_valid("t2", 60, lat);
        chk_val("t2_period", int'(period_out), 16);
        chk_val("t2_high", int'(high_out), 12);
        nv = 0;
        nt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid) nv++;
            if (timeout) nt++;
        end
        chk_val("t2_extra_valid", nv, 0);
        chk_val("t2_extra_timeout", nt, 0);
        chk_val("t2_busy_end", int'(busy), 0);

        // 3: sig_in held low, timeout after 21 edges
        gen_on = 1'b0;
        repeat (6) @(negedge clk);
        start   = 1'b1;
        nv      = 0;
        nt      = 0;
        first_t = -1;
        for (int e = 0; e <= 25; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (valid) nv++;
            if (timeout) begin
                nt++;
                if (first_t < 0) first_t = e;
            end
        end
        chk_val("t3_tmo_edge", first_t, 21);
        chk_val("t3_tmo_count", nt, 1);
        chk_val("t3_valid_count", nv, 0);
        chk_val("t3_period_hold", int'(period_out), 16);
        chk_val("t3_high_hold", int'(high_out), 12);
        chk_val("t3_busy", int'(busy), 0);

        // 4: reset during MEASURE, then a fresh measurement
        gen_p  = 8;
        gen_h  = 4;
        gen_on = 1'b1;
        wait_sig("t4a", 1'b0);
        pulse_start();
        wait_sig("t4b", 1'b1);
        repeat (4) @(negedge clk);
        chk_val("t4_busy_meas", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_val("t4_period", int'(period_out), 0);
        chk_val("t4_high", int'(high_out), 0);
        chk_val("t4_valid", int'(valid), 0);
        chk_val("t4_timeout", int'(timeout), 0);
        chk_val("t4_busy", int'(busy), 0);
        nv = 0;
        nt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (valid) nv++;
            if (timeout) nt++;
        end
        chk_val("t4_no_valid", nv, 0);
        chk_val("t4_no_timeout", nt, 0);
        wait_sig("t4c", 1'b0);
        pulse_start();
        wait_valid("t4", 40, lat);
        chk_val("t4_re_period", int'(period_out), 8);
        chk_val("t4_re_high", int'(high_out), 4);

        // 5: start coincides with a synced rise, period 6 high 3
        gen_p = 6;
        gen_h = 3;
        wait_sig("t5a", 1'b0);
        wait_sig("t5b", 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        lat   = -1;
        for (int e = 0; e <= 30; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (valid && lat < 0) lat = e;
        end
        chk_val("t5_valid_edge", lat, 12);
        chk_val("t5_period", int'(period_out), 6);
        chk_val("t5_high", int'(high_out), 3);

        // 6: back-to-back, period 8 then 10
        gen_p = 8;
        gen_h = 4;
        wait_sig("t6a", 1'b0);
        wait_sig("t6b", 1'b0);
        pulse_start();
        wait_valid("t6a", 40, lat);
        chk_val("t6_period_a", int'(period_out), 8);
        chk_val("t6_high_a", int'(high_out), 4);
        gen_p = 10;
        gen_h = 5;
        @(negedge clk);
        pulse_start();
        chk_val("t6_busy_b", int'(busy), 1);
        wait_valid("t6b", 50, lat);
        chk_val("t6_period_b", int'(period_out), 10);
        chk_val("t6_high_b", int'(high_out), 5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
